// File: rtl/sort_alpha_ctrl_pkg.sv
// State encoding and default constants for the sort_alpha_ctrl sorter front-end.
package sort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FEED    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_TOTAL_SYMBOLS = 10;
    localparam int DEF_ADDR_WIDTH    = 4;
    localparam int DEF_MAXHIGHT      = 10;
    localparam int DEF_TIMEOUT       = 40;

endpackage

// File: rtl/sort_alpha_ctrl.sv
// Snapshots a parallel symbol table, streams it serially into the sorter, then captures
// the sorted table. Optional WAIT timeout is enabled with macro SORT_ALPHA_CTRL_TIMEOUT_EN.
module sort_alpha_ctrl
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int TOTAL_SYMBOLS = DEF_TOTAL_SYMBOLS,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int MAXHIGHT      = DEF_MAXHIGHT,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] sym_in,
    input  logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] len_in,
    input  logic [TOTAL_SYMBOLS*MAXHIGHT-1:0]   code_in,
    output logic [DATA_WIDTH-1:0]               srt_muxin,
    output logic [ADDR_WIDTH-1:0]               srt_addr,
    output logic [MAXHIGHT-1:0]                 srt_codein,
    output logic                                srt_d_ena,
    output logic                                srt_d_sload,
    input  logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] srt_ob,
    input  logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] srt_oab,
    input  logic [TOTAL_SYMBOLS*MAXHIGHT-1:0]   srt_ocodeout,
    input  logic                                srt_done,
    output logic [TOTAL_SYMBOLS*DATA_WIDTH-1:0] sym_out,
    output logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] len_out,
    output logic [TOTAL_SYMBOLS*MAXHIGHT-1:0]   code_out,
    output logic                                busy,
    output logic                                out_valid,
    output logic                                err
);

    localparam int IW = $clog2(TOTAL_SYMBOLS) + 1;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   sym_tbl  [TOTAL_SYMBOLS];
    logic [ADDR_WIDTH-1:0]   len_tbl  [TOTAL_SYMBOLS];
    logic [MAXHIGHT-1:0]     code_tbl [TOTAL_SYMBOLS];

`ifdef SORT_ALPHA_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            srt_d_ena   <= 1'b0;
            srt_d_sload <= 1'b0;
            srt_muxin   <= '0;
            srt_addr    <= '0;
            srt_codein  <= '0;
            sym_out     <= '0;
            len_out     <= '0;
            code_out    <= '0;
            for (int i = 0; i < TOTAL_SYMBOLS; i++) begin
                sym_tbl[i]  <= '0;
                len_tbl[i]  <= '0;
                code_tbl[i] <= '0;
            end
`ifdef SORT_ALPHA_CTRL_TIMEOUT_EN
            err  <= 1'b0;
            wcnt <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Snapshot the table on accept so later input changes cannot leak in.
                        for (int i = 0; i < TOTAL_SYMBOLS; i++) begin
                            sym_tbl[i]  <= sym_in[i*DATA_WIDTH +: DATA_WIDTH];
                            len_tbl[i]  <= len_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                            code_tbl[i] <= code_in[i*MAXHIGHT +: MAXHIGHT];
                        end
                        idx         <= '0;
                        busy        <= 1'b1;
                        srt_d_sload <= 1'b1;
                        state       <= ST_LOAD;
`ifdef SORT_ALPHA_CTRL_TIMEOUT_EN
                        err <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    srt_d_sload <= 1'b0;
                    srt_d_ena   <= 1'b1;
                    srt_muxin   <= sym_tbl[0];
                    srt_addr    <= len_tbl[0];
                    srt_codein  <= code_tbl[0];
                    idx         <= IW'(1);
                    state       <= ST_FEED;
                end
                ST_FEED: begin
                    // idx is one ahead of the entry currently on the bus.
                    if (idx == IW'(TOTAL_SYMBOLS)) begin
                        state <= ST_WAIT;
`ifdef SORT_ALPHA_CTRL_TIMEOUT_EN
                        wcnt <= '0;
`endif
                    end else begin
                        srt_muxin  <= sym_tbl[idx[IW-2:0]];
                        srt_addr   <= len_tbl[idx[IW-2:0]];
                        srt_codein <= code_tbl[idx[IW-2:0]];
                        idx        <= idx + IW'(1);
                    end
                end
                ST_WAIT: begin
                    if (srt_done) begin
                        sym_out   <= srt_ob;
                        len_out   <= srt_oab;
                        code_out  <= srt_ocodeout;
                        out_valid <= 1'b1;
                        srt_d_ena <= 1'b0;
                        state     <= ST_CAPTURE;
                    end
`ifdef SORT_ALPHA_CTRL_TIMEOUT_EN
                    else if (wcnt == TW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        srt_d_ena <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
`endif
                end
                ST_CAPTURE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    srt_d_ena <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
